br_update_queue: RTL and testbench

- Sits between the integer execute pipes and the SAp predictor's resolved-branch update port.
- Buffers resolved branch results from the pipes in a circular FIFO.
- Drains them in program-arrival order, at most OUT_WIDTH per cycle.
- Never presents two drained results to the same PHT index in one cycle, which removes the multi-bank write conflicts inside the predictor.

---
 rtl/br_update_queue_pkg.sv | 27 ++
 rtl/br_update_queue_conflict_check.sv | 49 ++++
 rtl/br_update_queue.sv | 164 ++++++++++++++++
 tb/tb_br_update_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_update_queue_pkg.sv
// Shared fetch-unit types: resolved-branch update entry, queue depth and the
// PHT index extraction used by both the update queue and the SAp predictor.
package FetchUnitTypes;

    localparam int BR_UPDATE_QUEUE_ENTRY_NUM = 8;
    localparam int BR_ADDR_WIDTH             = 32;
    localparam int BR_PREV_WIDTH             = 40;
    localparam int BR_INSN_ADDR_BIT_WIDTH    = 2;
    localparam int BR_PHT_INDEX_BITS         = 8;

    typedef logic [BR_PHT_INDEX_BITS-1:0] PhtIndexPath;

    // One resolved branch as handed to the predictor's update port.
    typedef struct packed {
        logic [BR_ADDR_WIDTH-1:0] addr;
        logic                     taken;
        logic                     mispred;
        logic                     isCondBr;
        logic [BR_PREV_WIDTH-1:0] prev;
    } BrUpdateEntry;

    // PHT index: drop the instruction-offset bits, keep the next index bits.
    function automatic PhtIndexPath ToPhtIndex(input logic [BR_ADDR_WIDTH-1:0] addr);
        return addr[BR_PHT_INDEX_BITS-1+BR_INSN_ADDR_BIT_WIDTH : BR_INSN_ADDR_BIT_WIDTH];
    endfunction

endpackage

// File: rtl/br_update_queue_conflict_check.sv
// Drain-mask generator: a lane may drain only if every earlier lane drains
// and its PHT index differs from all earlier lanes of the same cycle.
module br_update_conflict_check
    import FetchUnitTypes::*;
#(
    parameter int OUT_WIDTH           = 2,
    parameter int ADDR_WIDTH          = BR_ADDR_WIDTH,
    parameter int INSN_ADDR_BIT_WIDTH = BR_INSN_ADDR_BIT_WIDTH,
    parameter int PHT_INDEX_BITS      = BR_PHT_INDEX_BITS
)(
    input  logic [OUT_WIDTH-1:0][ADDR_WIDTH-1:0] candAddr,
    input  logic [OUT_WIDTH-1:0]                 candAvail,
    output logic [OUT_WIDTH-1:0]                 drainMask
);

    logic [OUT_WIDTH-1:0][PHT_INDEX_BITS-1:0] candIndex;
    logic                                     unusedAddrBits;

    // Only the index field of each address takes part in the comparison.
    assign unusedAddrBits = ^candAddr;

    // Extract the PHT index of every candidate lane.
    always_comb begin
        candIndex = '0;
        for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
            candIndex[k] = candAddr[k][PHT_INDEX_BITS-1+INSN_ADDR_BIT_WIDTH -: PHT_INDEX_BITS];
        end
    end

    // Prefix chain: stop at the first unavailable or index-conflicting lane.
    always_comb begin
        logic chain;
        logic distinct;
        drainMask    = '0;
        chain        = candAvail[0];
        drainMask[0] = chain;
        for (int unsigned k = 1; k < OUT_WIDTH; k++) begin
            distinct = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (candIndex[j] == candIndex[k]) begin
                    distinct = 1'b0;
                end
            end
            chain        = chain && candAvail[k] && distinct;
            drainMask[k] = chain;
        end
    end

endmodule

// File: rtl/br_update_queue.sv
// Resolved-branch update queue: circular FIFO between the execute pipes and
// the predictor update port; drains in order without PHT index collisions.
module br_update_queue
    import FetchUnitTypes::*;
#(
    parameter int ENTRY_NUM           = BR_UPDATE_QUEUE_ENTRY_NUM,
    parameter int IN_WIDTH            = 2,
    parameter int OUT_WIDTH           = 2,
    parameter int ADDR_WIDTH          = BR_ADDR_WIDTH,
    parameter int INSN_ADDR_BIT_WIDTH = BR_INSN_ADDR_BIT_WIDTH,
    parameter int PHT_INDEX_BITS      = BR_PHT_INDEX_BITS,
    parameter int PREV_WIDTH          = BR_PREV_WIDTH
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IN_WIDTH-1:0]                   inValid,
    input  logic [IN_WIDTH-1:0][ADDR_WIDTH-1:0]   inAddr,
    input  logic [IN_WIDTH-1:0]                   inTaken,
    input  logic [IN_WIDTH-1:0]                   inMispred,
    input  logic [IN_WIDTH-1:0]                   inIsCondBr,
    input  logic [IN_WIDTH-1:0][PREV_WIDTH-1:0]   inPrev,
    input  logic                                  hold,
    output logic [OUT_WIDTH-1:0]                  outValid,
    output logic [OUT_WIDTH-1:0][ADDR_WIDTH-1:0]  outAddr,
    output logic [OUT_WIDTH-1:0]                  outTaken,
    output logic [OUT_WIDTH-1:0]                  outMispred,
    output logic [OUT_WIDTH-1:0]                  outIsCondBr,
    output logic [OUT_WIDTH-1:0][PREV_WIDTH-1:0]  outPrev,
    output logic [$clog2(ENTRY_NUM):0]            count,
    output logic                                  full,
    output logic                                  empty,
    output logic [15:0]                           dropCount
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  taken;
        logic                  mispred;
        logic                  isCondBr;
        logic [PREV_WIDTH-1:0] prev;
    } QueueEntry;

    QueueEntry                          storage [ENTRY_NUM];
    logic [PTR_W-1:0]                   headPtr;
    logic [PTR_W-1:0]                   tailPtr;

    logic [IN_WIDTH-1:0]                wrEn;
    logic [IN_WIDTH-1:0][PTR_W-1:0]     wrSlot;
    logic [CNT_W-1:0]                   nEnq;
    logic [15:0]                        nDrop;
    logic [16:0]                        dropSum;

    logic [OUT_WIDTH-1:0][PTR_W-1:0]    rdSlot;
    logic [OUT_WIDTH-1:0][ADDR_WIDTH-1:0] candAddr;
    logic [OUT_WIDTH-1:0]               candAvail;
    logic [OUT_WIDTH-1:0]               drainMask;
    logic [CNT_W-1:0]                   nDeq;

    // Compact valid input lanes onto free slots; overflow lanes are dropped.
    // Free space is taken from the registered count, so same-cycle drains
    // never make room for same-cycle arrivals.
    always_comb begin
        int unsigned freeSlots;
        int unsigned written;
        int unsigned dropped;
        freeSlots = ENTRY_NUM - 32'(count);
        written   = 0;
        dropped   = 0;
        wrEn      = '0;
        wrSlot    = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (inValid[i]) begin
                if (written < freeSlots) begin
                    wrEn[i]   = 1'b1;
                    wrSlot[i] = tailPtr + PTR_W'(written);
                    written   = written + 1;
                end else begin
                    dropped = dropped + 1;
                end
            end
        end
        nEnq  = CNT_W'(written);
        nDrop = 16'(dropped);
    end

    // Present the oldest entries; availability gated by reset, hold and occupancy.
    always_comb begin
        rdSlot      = '0;
        candAddr    = '0;
        candAvail   = '0;
        outAddr     = '0;
        outTaken    = '0;
        outMispred  = '0;
        outIsCondBr = '0;
        outPrev     = '0;
        for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
            rdSlot[k]      = headPtr + PTR_W'(k);
            candAddr[k]    = storage[rdSlot[k]].addr;
            candAvail[k]   = !rst && !hold && (32'(count) > k);
            outAddr[k]     = storage[rdSlot[k]].addr;
            outTaken[k]    = storage[rdSlot[k]].taken;
            outMispred[k]  = storage[rdSlot[k]].mispred;
            outIsCondBr[k] = storage[rdSlot[k]].isCondBr;
            outPrev[k]     = storage[rdSlot[k]].prev;
        end
    end

    br_update_conflict_check #(
        .OUT_WIDTH           (OUT_WIDTH),
        .ADDR_WIDTH          (ADDR_WIDTH),
        .INSN_ADDR_BIT_WIDTH (INSN_ADDR_BIT_WIDTH),
        .PHT_INDEX_BITS      (PHT_INDEX_BITS)
    ) conflictCheck (
        .candAddr  (candAddr),
        .candAvail (candAvail),
        .drainMask (drainMask)
    );

    assign outValid = drainMask;

    // Number drained this cycle; the mask is a prefix so a popcount suffices.
    always_comb begin
        nDeq = '0;
        for (int unsigned k = 0; k < OUT_WIDTH; k++) begin
            nDeq = nDeq + CNT_W'(drainMask[k]);
        end
    end

    assign dropSum = {1'b0, dropCount} + {1'b0, nDrop};
    assign full    = (count == CNT_W'(ENTRY_NUM));
    assign empty   = (count == '0);

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (wrEn[i]) begin
                storage[wrSlot[i]] <= '{addr:     inAddr[i],
                                        taken:    inTaken[i],
                                        mispred:  inMispred[i],
                                        isCondBr: inIsCondBr[i],
                                        prev:     inPrev[i]};
            end
        end
    end

    // Pointer, occupancy and saturating drop-counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            count     <= '0;
            dropCount <= '0;
        end else begin
            headPtr   <= headPtr + PTR_W'(nDeq);
            tailPtr   <= tailPtr + PTR_W'(nEnq);
            count     <= count + nEnq - nDeq;
            dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

endmodule

// File: tb/tb_br_update_queue.sv
// Bench for br_update_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_br_update_queue;

    localparam int IW = 2;
    localparam int OW = 2;
    localparam int ENTRIES = 8;

    logic             clk;
    logic             rst;
    logic             hold;
    logic [IW-1:0]    inValid, inTaken, inMispred, inIsCondBr;
    logic [IW-1:0][31:0] inAddr;
    logic [IW-1:0][39:0] inPrev;
    logic [OW-1:0]    outValid, outTaken, outMispred, outIsCondBr;
    logic [OW-1:0][31:0] outAddr;
    logic [OW-1:0][39:0] outPrev;
    logic [3:0]       count;
    logic             full, empty;
    logic [15:0]      dropCount;

    br_update_queue #(
        .ENTRY_NUM           (ENTRIES),
        .IN_WIDTH            (IW),
        .OUT_WIDTH           (OW),
        .ADDR_WIDTH          (32),
        .INSN_ADDR_BIT_WIDTH (2),
        .PHT_INDEX_BITS      (8),
        .PREV_WIDTH          (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .inAddr      (inAddr),
        .inTaken     (inTaken),
        .inMispred   (inMispred),
        .inIsCondBr  (inIsCondBr),
        .inPrev      (inPrev),
        .hold        (hold),
        .outValid    (outValid),
        .outAddr     (outAddr),
        .outTaken    (outTaken),
        .outMispred  (outMispred),
        .outIsCondBr (outIsCondBr),
        .outPrev     (outPrev),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .dropCount   (dropCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic        mispred;
        logic        cond;
        logic [39:0] prev;
    } ModelEnt;

    ModelEnt     mq[$];
    int unsigned mDrop;
    int          checks;
    int          failures;

    function automatic int unsigned phtIdx(input logic [31:0] a);
        return (a / 4) % 256;
    endfunction

    // How many queue-front entries the predictor may receive this cycle.
    function automatic int unsigned expDrainCount();
        int unsigned n;
        if (rst || hold) return 0;
        n = 0;
        while (n < OW && n < mq.size()) begin
            for (int unsigned j = 0; j < n; j++) begin
                if (phtIdx(mq[j].addr) == phtIdx(mq[n].addr)) return n;
            end
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compareAll();
        int unsigned nd;
        logic [OW-1:0] expMask;
        nd = expDrainCount();
        expMask = '0;
        for (int unsigned k = 0; k < nd; k++) expMask[k] = 1'b1;
        check("outValid", 128'(outValid), 128'(expMask));
        for (int unsigned k = 0; k < nd; k++) begin
            check($sformatf("lane%0d_payload", k),
                  128'({outAddr[k], outTaken[k], outMispred[k], outIsCondBr[k], outPrev[k]}),
                  128'({mq[k].addr, mq[k].taken, mq[k].mispred, mq[k].cond, mq[k].prev}));
        end
        check("count", 128'(count), 128'(mq.size()));
        check("full", 128'(full), 128'(mq.size() == ENTRIES));
        check("empty", 128'(empty), 128'(mq.size() == 0));
        check("dropCount", 128'(dropCount), 128'(mDrop));
    endtask

    // Apply this cycle's edge to the model: drain, then accept up to the
    // free space seen at the start of the cycle.
    task automatic modelAdvance();
        int unsigned freeSlots, nd, written, dropped;
        ModelEnt e;
        if (rst) begin
            mq.delete();
            mDrop = 0;
            return;
        end
        freeSlots = ENTRIES - mq.size();
        nd = expDrainCount();
        for (int unsigned k = 0; k < nd; k++) void'(mq.pop_front());
        written = 0;
        dropped = 0;
        for (int unsigned i = 0; i < IW; i++) begin
            if (inValid[i]) begin
                if (written < freeSlots) begin
                    e.addr = inAddr[i]; e.taken = inTaken[i]; e.mispred = inMispred[i];
                    e.cond = inIsCondBr[i]; e.prev = inPrev[i];
                    mq.push_back(e);
                    written++;
                end else begin
                    dropped++;
                end
            end
        end
        mDrop = (mDrop + dropped > 65535) ? 65535 : mDrop + dropped;
    endtask

    task automatic clearIn();
        inValid = '0; inAddr = '0; inTaken = '0; inMispred = '0; inIsCondBr = '0; inPrev = '0;
    endtask

    task automatic setIn(input int unsigned lane, input logic [31:0] a, input logic t,
                         input logic m, input logic c, input logic [39:0] p);
        inValid[lane] = 1'b1; inAddr[lane] = a; inTaken[lane] = t;
        inMispred[lane] = m; inIsCondBr[lane] = c; inPrev[lane] = p;
    endtask

    task automatic settle();
        #4;
        compareAll();
    endtask

    task automatic advance();
        modelAdvance();
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; mDrop = 0;
        rst = 1'b1; hold = 1'b0; clearIn();
        settle(); advance();
        settle(); check("rst_outValid", 128'(outValid), 128'(0)); advance();
        rst = 1'b0;
        settle(); check("reset_empty", 128'(empty), 128'(1)); advance();

        // Single result
        setIn(0, 32'h1004, 1'b1, 1'b0, 1'b1, 40'h11);
        settle(); advance(); clearIn();
        settle();
        check("single_valid", 128'(outValid), 128'(2'b01));
        check("single_addr", 128'(outAddr[0]), 128'(32'h1004));
        check("single_taken", 128'(outTaken[0]), 128'(1));
        advance();
        settle();
        check("single_count", 128'(count), 128'(0));
        check("single_empty", 128'(empty), 128'(1));
        advance();

        // Dual, distinct index
        setIn(0, 32'h1000, 1'b0, 1'b1, 1'b1, 40'h21);
        setIn(1, 32'h1008, 1'b1, 1'b0, 1'b0, 40'h22);
        settle(); advance(); clearIn();
        settle();
        check("dual_valid", 128'(outValid), 128'(2'b11));
        check("dual_addr1", 128'(outAddr[1]), 128'(32'h1008));
        check("dual_count", 128'(count), 128'(2));
        advance();
        settle(); check("dual_count_after", 128'(count), 128'(0)); advance();

        // Dual, same index
        setIn(0, 32'h1000, 1'b1, 1'b0, 1'b1, 40'h31);
        setIn(1, 32'h1400, 1'b0, 1'b0, 1'b1, 40'h32);
        settle(); advance(); clearIn();
        settle();
        check("same1_valid", 128'(outValid), 128'(2'b01));
        check("same1_addr", 128'(outAddr[0]), 128'(32'h1000));
        advance();
        settle();
        check("same2_valid", 128'(outValid), 128'(2'b01));
        check("same2_addr", 128'(outAddr[0]), 128'(32'h1400));
        advance();

        // Overflow under hold, then drain across the wrap point
        hold = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            setIn(0, 32'h2000 + 8 * c, 1'b1, 1'b0, 1'b1, 40'(c));
            setIn(1, 32'h2004 + 8 * c, 1'b0, 1'b1, 1'b1, 40'(c + 100));
            settle(); advance();
        end
        clearIn();
        settle();
        check("ovf_count", 128'(count), 128'(8));
        check("ovf_full", 128'(full), 128'(1));
        check("ovf_drop", 128'(dropCount), 128'(2));
        advance();
        hold = 1'b0;
        settle();
        check("ovf_first_addr", 128'(outAddr[0]), 128'(32'h2000));
        advance();
        for (int unsigned c = 0; c < 5; c++) begin
            settle(); advance();
        end
        settle(); check("ovf_drained", 128'(empty), 128'(1)); advance();

        // Hold while results arrive
        hold = 1'b1;
        setIn(0, 32'h5000, 1'b1, 1'b1, 1'b0, 40'h51);
        setIn(1, 32'h5004, 1'b0, 1'b1, 1'b0, 40'h52);
        settle(); check("hold_v0", 128'(outValid), 128'(0)); advance();
        clearIn(); setIn(0, 32'h5008, 1'b1, 1'b0, 1'b0, 40'h53);
        settle(); check("hold_v1", 128'(outValid), 128'(0)); advance();
        clearIn();
        settle(); check("hold_v2", 128'(outValid), 128'(0)); advance();
        hold = 1'b0;
        settle();
        check("hold_rel_valid", 128'(outValid), 128'(2'b11));
        check("hold_rel_addr0", 128'(outAddr[0]), 128'(32'h5000));
        advance();
        settle();
        check("hold_rel2_valid", 128'(outValid), 128'(2'b01));
        check("hold_rel2_addr", 128'(outAddr[0]), 128'(32'h5008));
        advance();

        // Reset mid-operation (count 5, dropCount 3)
        rst = 1'b1; settle(); advance(); rst = 1'b0;
        hold = 1'b1;
        for (int unsigned c = 0; c < 6; c++) begin
            clearIn();
            setIn(0, 32'h3000 + 8 * c, 1'b1, 1'b0, 1'b1, 40'(c));
            if (c == 0) setIn(1, 32'h3400, 1'b0, 1'b0, 1'b1, 40'h99);
            else if (c < 5) setIn(1, 32'h3004 + 8 * c, 1'b0, 1'b0, 1'b1, 40'(c + 50));
            settle(); advance();
        end
        clearIn();
        hold = 1'b0;
        settle(); advance();
        settle(); advance();
        rst = 1'b1;
        settle();
        check("mid_count", 128'(count), 128'(5));
        check("mid_drop", 128'(dropCount), 128'(3));
        check("mid_rst_valid", 128'(outValid), 128'(0));
        advance();
        rst = 1'b0;
        setIn(0, 32'h7004, 1'b1, 1'b0, 1'b1, 40'h77);
        settle();
        check("post_rst_count", 128'(count), 128'(0));
        check("post_rst_drop", 128'(dropCount), 128'(0));
        check("post_rst_empty", 128'(empty), 128'(1));
        check("post_rst_valid", 128'(outValid), 128'(0));
        advance();
        clearIn();
        settle();
        check("post_rst_new_valid", 128'(outValid), 128'(2'b01));
        check("post_rst_new_addr", 128'(outAddr[0]), 128'(32'h7004));
        advance();

        // Random traffic with frequent PHT index collisions
        for (int unsigned cyc = 0; cyc < 800; cyc++) begin
            rst  = ($urandom_range(0, 99) == 0);
            hold = ($urandom_range(0, 3) == 0);
            clearIn();
            for (int unsigned i = 0; i < IW; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    setIn(i,
                          ($urandom & ~32'h0000_03FC) | (32'($urandom_range(0, 3)) << 2),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          {8'($urandom), 32'($urandom)});
                end
            end
            settle(); advance();
        end
        rst = 1'b0; hold = 1'b0; clearIn();
        for (int unsigned cyc = 0; cyc < 10; cyc++) begin
            settle(); advance();
        end
        check("final_empty", 128'(empty), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
